// File: rtl/rob_pkg.sv
// Shared ROB/rename types: tag width, the "not renamed" tag value and the
// rename controller's sequencing states.
package rob_pkg;
   localparam int ROBsize      = 32;
   localparam int mapValueSize = $clog2(ROBsize + 1);

   typedef logic [mapValueSize-1:0] tag_t;
   localparam tag_t NO_TAG = '0;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_FLUSH,
      ST_HOLD
   } rename_state_e;
endpackage

// File: rtl/tag_ring_ptr.sv
// Ring pointer over ROB tags 1..ROBsize; tag 0 is reserved, so the pointer
// never takes that value.
module tag_ring_ptr #(
   parameter int ROBsize = 32,
   parameter int W       = $clog2(ROBsize + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] ptr_o
);
   logic [W-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr_i)
         ptr_d = W'(1);
      else if (inc_i)
         ptr_d = (ptr_q == W'(ROBsize)) ? W'(1) : ptr_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= W'(1);
      else       ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;
endmodule

// File: rtl/rename_ctrl.sv
// Rename controller: hands out ROB tags, drives map-table rename writes and
// commit-time clears, and sequences flush (global clear plus a fixed hold).
module rename_ctrl
   import rob_pkg::*;
#(
   parameter int ROBsize      = rob_pkg::ROBsize,
   parameter int mapValueSize = $clog2(ROBsize + 1),
   parameter int FLUSH_HOLD   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    dec_valid_i,
   output logic                    dec_ready_o,
   input  logic                    dec_regWrite_i,
   input  logic [4:0]              dec_rd_i,
   output logic [mapValueSize-1:0] dec_tag_o,
   output logic [4:0]              map_writeAddr_o,
   output logic [mapValueSize-1:0] map_writeData_o,
   output logic                    map_regWrite_o,
   input  logic                    com_valid_i,
   input  logic                    com_regWrite_i,
   input  logic [4:0]              com_rd_i,
   output logic [4:0]              map_commitAddr_o,
   input  logic [mapValueSize-1:0] map_commitData_i,
   output logic [31:0]             map_resets_o,
   output logic                    map_reset_o,
   input  logic                    flush_i,
   output logic [mapValueSize-1:0] occupancy_o
);
   localparam int HW = $clog2(FLUSH_HOLD + 1);

   rename_state_e           state_q;
   logic [HW-1:0]           hold_q;
   logic                    map_reset_q;
   logic [mapValueSize-1:0] count_q, count_d;
   logic [mapValueSize-1:0] head, tail;
   logic                    accept, commit, ptr_clr, clear_en;

   assign ptr_clr = (state_q == ST_FLUSH);

   tag_ring_ptr #(.ROBsize(ROBsize), .W(mapValueSize)) u_tail (
      .clk(clk), .reset(reset), .clr_i(ptr_clr), .inc_i(accept), .ptr_o(tail)
   );

   tag_ring_ptr #(.ROBsize(ROBsize), .W(mapValueSize)) u_head (
      .clk(clk), .reset(reset), .clr_i(ptr_clr), .inc_i(commit), .ptr_o(head)
   );

   assign dec_ready_o = ~reset & (state_q == ST_RUN) & ~flush_i &
                        (count_q < mapValueSize'(ROBsize));
   assign accept      = dec_valid_i & dec_ready_o;
   // Retirement only counts in RUN with something live; flush drops it.
   assign commit      = ~reset & com_valid_i & (state_q == ST_RUN) & ~flush_i &
                        (count_q != '0);

   assign dec_tag_o        = tail;
   assign map_writeAddr_o  = dec_rd_i;
   assign map_writeData_o  = tail;
   assign map_regWrite_o   = accept & dec_regWrite_i & (dec_rd_i != 5'd0);
   assign map_commitAddr_o = com_rd_i;
   assign map_reset_o      = map_reset_q;
   assign occupancy_o      = count_q;

   // Clear only if the entry still holds the retiring tag and is not being
   // renamed again this very cycle.
   assign clear_en = commit & com_regWrite_i & (com_rd_i != 5'd0) &
                     (map_commitData_i == head) &
                     ~(map_regWrite_o & (map_writeAddr_o == com_rd_i));

   always_comb begin
      map_resets_o = '0;
      if (clear_en) map_resets_o[com_rd_i] = 1'b1;
   end

   always_comb begin
      count_d = count_q;
      if (ptr_clr)
         count_d = '0;
      else if (accept && !commit)
         count_d = count_q + mapValueSize'(1);
      else if (commit && !accept)
         count_d = count_q - mapValueSize'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         hold_q      <= '0;
         map_reset_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (flush_i) begin
                  state_q     <= ST_FLUSH;
                  map_reset_q <= 1'b1;
               end
            end
            ST_FLUSH: begin
               state_q     <= ST_HOLD;
               hold_q      <= HW'(FLUSH_HOLD);
               map_reset_q <= 1'b0;
            end
            ST_HOLD: begin
               if (flush_i) begin
                  state_q     <= ST_FLUSH;
                  map_reset_q <= 1'b1;
               end else begin
                  hold_q <= hold_q - HW'(1);
                  if (hold_q == HW'(1)) state_q <= ST_RUN;
               end
            end
            default: begin
               state_q     <= ST_RUN;
               map_reset_q <= 1'b0;
            end
         endcase
      end
   end

   a_no_commit_when_empty: assert property (@(posedge clk) disable iff (reset)
      !(com_valid_i && (state_q == ST_RUN) && !flush_i && (count_q == '0)));
endmodule

// File: tb/tb_rename_ctrl.sv
// Directed bench for rename_ctrl; map writes and clears are scoreboarded.
module tb_rename_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        dec_valid_i = 1'b0, dec_ready_o, dec_regWrite_i = 1'b0;
   logic [4:0]  dec_rd_i = '0;
   logic [5:0]  dec_tag_o;
   logic [4:0]  map_writeAddr_o;
   logic [5:0]  map_writeData_o;
   logic        map_regWrite_o;
   logic        com_valid_i = 1'b0, com_regWrite_i = 1'b0;
   logic [4:0]  com_rd_i = '0;
   logic [4:0]  map_commitAddr_o;
   logic [5:0]  map_commitData_i = '0;
   logic [31:0] map_resets_o;
   logic        map_reset_o;
   logic        flush_i = 1'b0;
   logic [5:0]  occupancy_o;

   typedef struct { logic [4:0] a; logic [5:0] d; } wr_t;
   wr_t         wq[$];
   logic [31:0] rq[$];
   int errs = 0, checks = 0;

   always #5 clk = ~clk;

   rename_ctrl dut (
      .clk(clk), .reset(reset),
      .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
      .dec_regWrite_i(dec_regWrite_i), .dec_rd_i(dec_rd_i), .dec_tag_o(dec_tag_o),
      .map_writeAddr_o(map_writeAddr_o), .map_writeData_o(map_writeData_o),
      .map_regWrite_o(map_regWrite_o),
      .com_valid_i(com_valid_i), .com_regWrite_i(com_regWrite_i), .com_rd_i(com_rd_i),
      .map_commitAddr_o(map_commitAddr_o), .map_commitData_i(map_commitData_i),
      .map_resets_o(map_resets_o), .map_reset_o(map_reset_o),
      .flush_i(flush_i), .occupancy_o(occupancy_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic acc(input logic [4:0] rd, input logic rw, input int etag);
      dec_valid_i = 1'b1; dec_regWrite_i = rw; dec_rd_i = rd;
      if (rw && rd != 5'd0) wq.push_back('{rd, 6'(etag)});
      #1;
      chk("acc_ready", 32'(dec_ready_o), 32'd1);
      chk("acc_tag", 32'(dec_tag_o), 32'(etag));
      chk("acc_regwr", 32'(map_regWrite_o), 32'(rw && rd != 5'd0));
      tick();
      dec_valid_i = 1'b0; dec_regWrite_i = 1'b0; dec_rd_i = '0;
   endtask

   task automatic com(input logic [4:0] rd, input logic rw, input logic [5:0] data,
                      input logic [31:0] mask);
      com_valid_i = 1'b1; com_regWrite_i = rw; com_rd_i = rd; map_commitData_i = data;
      if (mask != 0) rq.push_back(mask);
      #1;
      chk("com_resets", map_resets_o, mask);
      chk("com_addr", 32'(map_commitAddr_o), 32'(rd));
      tick();
      com_valid_i = 1'b0; com_regWrite_i = 1'b0; com_rd_i = '0; map_commitData_i = '0;
   endtask

   // Map-table side: every write or clear the DUT issues must be expected.
   always @(negedge clk) begin
      wr_t e;
      if (!reset) begin
         if (map_regWrite_o) begin
            if (wq.size() == 0) chk("wr_unexpected", 32'(map_regWrite_o), 32'd0);
            else begin
               e = wq.pop_front();
               chk("wr_addr", 32'(map_writeAddr_o), 32'(e.a));
               chk("wr_data", 32'(map_writeData_o), 32'(e.d));
            end
         end
         if (map_resets_o != 32'd0) begin
            if (rq.size() == 0) chk("rs_unexpected", map_resets_o, 32'd0);
            else chk("rs_mask", map_resets_o, rq.pop_front());
         end
      end
   end

   initial begin
      tick(); tick();
      chk("rst_ready", 32'(dec_ready_o), 32'd0);
      chk("rst_tag", 32'(dec_tag_o), 32'd1);
      chk("rst_occ", 32'(occupancy_o), 32'd0);
      chk("rst_mreset", 32'(map_reset_o), 32'd0);
      chk("rst_resets", map_resets_o, 32'd0);
      chk("rst_regwr", 32'(map_regWrite_o), 32'd0);
      reset = 1'b0; #1;
      chk("run_ready", 32'(dec_ready_o), 32'd1);

      acc(5'd5, 1'b1, 1);
      acc(5'd6, 1'b1, 2);
      acc(5'd5, 1'b1, 3);
      #1 chk("occ3", 32'(occupancy_o), 32'd3);

      com(5'd5, 1'b1, 6'd3, 32'h0);          // stale: r5 already renamed to tag 3
      com(5'd6, 1'b1, 6'd2, 32'h40);
      #1 chk("occ1", 32'(occupancy_o), 32'd1);

      // retire r6 (head=3) while renaming r6 again: rename wins
      dec_valid_i = 1'b1; dec_regWrite_i = 1'b1; dec_rd_i = 5'd6;
      com_valid_i = 1'b1; com_regWrite_i = 1'b1; com_rd_i = 5'd6; map_commitData_i = 6'd3;
      wq.push_back('{5'd6, 6'd4});
      #1;
      chk("same_tag", 32'(dec_tag_o), 32'd4);
      chk("same_resets", map_resets_o, 32'd0);
      chk("same_regwr", 32'(map_regWrite_o), 32'd1);
      tick();
      dec_valid_i = 1'b0; dec_regWrite_i = 1'b0; dec_rd_i = '0;
      com_valid_i = 1'b0; com_regWrite_i = 1'b0; com_rd_i = '0; map_commitData_i = '0;
      #1 chk("same_occ", 32'(occupancy_o), 32'd1);

      for (int i = 0; i < 31; i++) acc(5'((i % 31) + 1), 1'b1, ((4 + i) % 32) + 1);
      #1;
      chk("full_ready", 32'(dec_ready_o), 32'd0);
      chk("full_occ", 32'(occupancy_o), 32'd32);
      chk("full_tag", 32'(dec_tag_o), 32'd4);
      dec_valid_i = 1'b1; dec_regWrite_i = 1'b1; dec_rd_i = 5'd7;
      #1 chk("full_regwr", 32'(map_regWrite_o), 32'd0);
      tick();
      dec_valid_i = 1'b0; dec_regWrite_i = 1'b0; dec_rd_i = '0;
      #1 chk("full_occ_hold", 32'(occupancy_o), 32'd32);
      com(5'd0, 1'b0, 6'd0, 32'h0);
      #1;
      chk("unfull_ready", 32'(dec_ready_o), 32'd1);
      chk("unfull_occ", 32'(occupancy_o), 32'd31);

      for (int i = 0; i < 21; i++) com(5'd0, 1'b0, 6'd0, 32'h0);
      #1 chk("occ10", 32'(occupancy_o), 32'd10);

      flush_i = 1'b1; #1;
      chk("fl_req_ready", 32'(dec_ready_o), 32'd0);
      chk("fl_req_mreset", 32'(map_reset_o), 32'd0);
      tick();
      flush_i = 1'b0; #1;
      chk("fl_mreset", 32'(map_reset_o), 32'd1);
      chk("fl_ready", 32'(dec_ready_o), 32'd0);
      chk("fl_regwr", 32'(map_regWrite_o), 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 0) begin
            com_valid_i = 1'b1; com_regWrite_i = 1'b1; com_rd_i = 5'd3; map_commitData_i = 6'd1;
         end
         #1;
         chk("hold_mreset", 32'(map_reset_o), 32'd0);
         chk("hold_ready", 32'(dec_ready_o), 32'd0);
         chk("hold_resets", map_resets_o, 32'd0);
         tick();
         com_valid_i = 1'b0; com_regWrite_i = 1'b0; com_rd_i = '0; map_commitData_i = '0;
      end
      #1;
      chk("post_ready", 32'(dec_ready_o), 32'd1);
      chk("post_tag", 32'(dec_tag_o), 32'd1);
      chk("post_occ", 32'(occupancy_o), 32'd0);

      acc(5'd0, 1'b1, 1);
      #1;
      chk("rd0_tag", 32'(dec_tag_o), 32'd2);
      chk("rd0_occ", 32'(occupancy_o), 32'd1);

      flush_i = 1'b1; tick();
      flush_i = 1'b0; tick();
      tick();
      reset = 1'b1; #1;
      chk("rsth_ready", 32'(dec_ready_o), 32'd0);
      tick();
      chk("rsth_tag", 32'(dec_tag_o), 32'd1);
      chk("rsth_occ", 32'(occupancy_o), 32'd0);
      chk("rsth_mreset", 32'(map_reset_o), 32'd0);
      reset = 1'b0; #1;
      chk("rsth_run_ready", 32'(dec_ready_o), 32'd1);

      chk("wq_drained", 32'(wq.size()), 32'd0);
      chk("rq_drained", 32'(rq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
